ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/cpu_pkg.sv | 19 +
 rtl/ifetch_fifo.sv | 53 +++++
 rtl/ifetch_unit.sv | 146 ++++++++++++++
 tb/tb_ifetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, default PC step, fetch FSM states and fetch-queue entry layout.
package cpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned PC_STEP_DEF = 4;
  localparam int unsigned ENTRY_W     = 2 * XLEN;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Fetched-instruction queue: power-of-two depth FIFO with synchronous flush.
module ifetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  // Storage is cleared on reset so the head word reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[PTR_W'(i)] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      if (i_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!i_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: single-outstanding request FSM feeding a queue to decode.
// Optional stall counter port perf_stall_cnt is built when IFETCH_PERF_CNT_EN is defined.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned PC_STEP    = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] current_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
`ifdef IFETCH_PERF_CNT_EN
  output logic [XLEN-1:0] perf_stall_cnt,
`endif
  input  logic            if_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic            r_drop;
  logic            w_drop_nxt;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] w_req_pc_nxt;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_cnt_after_push;
  logic             w_slot_now;
  logic             w_slot_push;
  fetch_entry_t     w_push_data;
  fetch_entry_t     w_head;

  assign imem_addr   = {current_pc[XLEN-1:2], 2'b00};
  assign w_pop       = if_valid & if_ready;
  assign if_valid    = ~w_empty;
  assign if_pc       = w_head.pc;
  assign if_instr    = w_head.instr;
  assign w_push_data = '{pc: r_req_pc, instr: imem_rdata};

  // Slot rule: queued entries plus the in-flight request must stay below depth.
  assign w_cnt_after_push = w_count + CNT_W'(1) - CNT_W'(w_pop);
  assign w_slot_now       = (w_count < CNT_W'(FIFO_DEPTH));
  assign w_slot_push      = (w_cnt_after_push < CNT_W'(FIFO_DEPTH));

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FETCH_IDLE;
      r_drop   <= 1'b0;
      r_req_pc <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_drop   <= w_drop_nxt;
      r_req_pc <= w_req_pc_nxt;
    end
  end

  // Next state, PC selection and request/push control.
  always_comb begin
    w_state_nxt  = r_state;
    w_drop_nxt   = r_drop;
    w_req_pc_nxt = r_req_pc;
    next_pc      = current_pc;
    imem_req     = 1'b0;
    w_push       = 1'b0;

    case (r_state)
      FETCH_IDLE: begin
        if (!redirect_valid && w_slot_now) w_state_nxt = FETCH_REQ;
      end
      FETCH_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          w_req_pc_nxt = current_pc;
          next_pc      = current_pc + XLEN'(PC_STEP);
          w_state_nxt  = FETCH_WAIT;
          if (redirect_valid) w_drop_nxt = 1'b1;
        end else if (redirect_valid) begin
          w_state_nxt = FETCH_IDLE;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          if (!r_drop && !redirect_valid) begin
            w_push      = 1'b1;
            w_state_nxt = w_slot_push ? FETCH_REQ : FETCH_IDLE;
          end else begin
            // Stale response from a redirected path is discarded.
            w_drop_nxt  = 1'b0;
            w_state_nxt = (!redirect_valid && w_slot_now) ? FETCH_REQ : FETCH_IDLE;
          end
        end else if (redirect_valid) begin
          w_drop_nxt = 1'b1;
        end
      end
      default: w_state_nxt = FETCH_IDLE;
    endcase

    if (redirect_valid) next_pc = redirect_pc;
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [XLEN-1:0] r_stall_cnt;

  // Cycles with nothing to offer decode, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!if_valid && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + XLEN'(1);
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a PC register and a fixed-latency memory model.
module tb_ifetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rst_pc = 32'h0;
  logic [31:0] current_pc;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
`endif

  int unsigned lat = 1;
  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] req_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_ins_q[$];

  logic        m_busy;
  int unsigned m_cnt;
  logic [31:0] m_addr;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .current_pc     (current_pc),
    .next_pc        (next_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
`ifdef IFETCH_PERF_CNT_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .if_ready       (if_ready)
  );

  // PC register loads next_pc every edge.
  always @(posedge clk or posedge rst) begin
    if (rst) current_pc <= rst_pc;
    else     current_pc <= next_pc;
  end

  // Memory: returns addr ^ 0xA5A50000 'lat' cycles after a granted request.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy      <= 1'b0;
      m_cnt       <= 0;
      m_addr      <= 32'h0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
    end else begin
      imem_rvalid <= 1'b0;
      if (m_busy) begin
        if (m_cnt <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= m_addr ^ 32'hA5A5_0000;
          m_busy      <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (imem_req && imem_gnt) begin
        if (lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= imem_addr ^ 32'hA5A5_0000;
        end else begin
          m_busy <= 1'b1;
          m_cnt  <= lat - 1;
          m_addr <= imem_addr;
        end
      end
    end
  end

  // Record accepted requests and decode handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && imem_gnt) req_q.push_back(imem_addr);
      if (if_valid && if_ready) begin
        pop_pc_q.push_back(if_pc);
        pop_ins_q.push_back(if_instr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] req_at(input int i);
    return (req_q.size() > i) ? req_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pop_pc_at(input int i);
    return (pop_pc_q.size() > i) ? pop_pc_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pop_ins_at(input int i);
    return (pop_ins_q.size() > i) ? pop_ins_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    rst_pc = pc;
    rst    = 1'b1;
    step_cycle();
    step_cycle();
    req_q.delete();
    pop_pc_q.delete();
    pop_ins_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    int cnt8;
    bit hit;

    // Reset values
    do_reset(32'h0);
    rst = 1'b1;
    #1;
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_if_pc",    if_pc,             32'h0);
    chk("rst_if_instr", if_instr,          32'h0);
`ifdef IFETCH_PERF_CNT_EN
    chk("rst_perf",     perf_stall_cnt,    32'h0);
`endif

    // Sequential fetch, one-cycle memory
    imem_gnt = 1'b1; lat = 1; if_ready = 1'b1;
    do_reset(32'h0);
    repeat (14) step_cycle();
    chk("seq_req0", req_at(0), 32'h0);
    chk("seq_req1", req_at(1), 32'h4);
    chk("seq_req2", req_at(2), 32'h8);
    chk("seq_pc0",  pop_pc_at(0), 32'h0);
    chk("seq_pc1",  pop_pc_at(1), 32'h4);
    chk("seq_pc2",  pop_pc_at(2), 32'h8);
    chk("seq_ins0", pop_ins_at(0), 32'hA5A5_0000);
    chk("seq_ins2", pop_ins_at(2), 32'hA5A5_0008);

    // Back-pressure fills the two-entry queue
    if_ready = 1'b0;
    do_reset(32'h0);
    repeat (12) step_cycle();
    chk("bp_nreq",     32'(req_q.size()), 32'd2);
    chk("bp_imem_req", {31'h0, imem_req}, 32'h0);
    chk("bp_if_valid", {31'h0, if_valid}, 32'h1);
    chk("bp_next_pc",  next_pc,           32'h8);
    chk("bp_if_pc",    if_pc,             32'h0);
    if_ready = 1'b1;
    repeat (12) step_cycle();
    chk("bp_pc0", pop_pc_at(0), 32'h0);
    chk("bp_pc1", pop_pc_at(1), 32'h4);
    chk("bp_pc2", pop_pc_at(2), 32'h8);

    // Grant withheld: request held stable
    imem_gnt = 1'b0;
    do_reset(32'h100);
    step_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_req",     {31'h0, imem_req}, 32'h1);
      chk("hold_addr",    imem_addr,         32'h100);
      chk("hold_next_pc", next_pc,           32'h100);
      step_cycle();
    end
    imem_gnt = 1'b1;
    #1;
    chk("hold_gnt_next_pc", next_pc, 32'h104);

    // PC wrap at top of address space
    imem_gnt = 1'b0;
    do_reset(32'hFFFF_FFFC);
    step_cycle();
    imem_gnt = 1'b1;
    #1;
    chk("wrap_addr",    imem_addr, 32'hFFFF_FFFC);
    chk("wrap_next_pc", next_pc,   32'h0);
    step_cycle();
    chk("wrap_cur_pc",  current_pc, 32'h0);

    // Redirect while waiting on 0x8
    imem_gnt = 1'b1; lat = 3; if_ready = 1'b1;
    do_reset(32'h0);
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step_cycle();
      if (req_q.size() >= 3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("redir_wait_timeout", {31'h0, hit}, 32'h1);
    chk("redir_req2", req_at(2), 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2000;
    #1;
    chk("redir_next_pc", next_pc, 32'h2000);
    step_cycle();
    redirect_valid = 1'b0;
    repeat (20) step_cycle();
    chk("redir_req3", req_at(3), 32'h2000);
    cnt8 = 0;
    foreach (pop_pc_q[i]) if (pop_pc_q[i] == 32'h8) cnt8++;
    chk("redir_no_pc8", 32'(cnt8), 32'd0);
    chk("redir_pc2",  pop_pc_at(2),  32'h2000);
    chk("redir_ins2", pop_ins_at(2), 32'hA5A5_2000);

`ifdef IFETCH_PERF_CNT_EN
    // Stall counter with an empty queue
    imem_gnt = 1'b0; lat = 1;
    do_reset(32'h0);
    repeat (7) step_cycle();
    chk("perf_7", perf_stall_cnt, 32'd7);
    rst = 1'b1;
    #1;
    chk("perf_rst", perf_stall_cnt, 32'd0);
    step_cycle();
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
